// File: rtl/led_control_pkg.sv
// ----------------------------------------------------------------------------
// led_control_pkg
// Shared constants and types for the AXI4-Lite LED controller:
//   - register byte offsets (decoded on address bits [3:2])
//   - CTRL bit position of the blink enable
//   - AXI response code
//   - write / read FSM state types and encodings
//   - apply_wstrb(): byte-lane merge of write data into a register
// ----------------------------------------------------------------------------
package led_control_pkg;

   localparam logic [3:0] REG_PATTERN_OFF = 4'h0;
   localparam logic [3:0] REG_PERIOD_OFF  = 4'h4;
   localparam logic [3:0] REG_CTRL_OFF    = 4'h8;
   localparam logic [3:0] REG_SCRATCH_OFF = 4'hC;

   localparam int CTRL_BLINK_EN_BIT = 0;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef logic [0:0] w_state_t;
   localparam w_state_t W_IDLE = 1'b0;
   localparam w_state_t W_RESP = 1'b1;

   typedef logic [0:0] r_state_t;
   localparam r_state_t R_IDLE = 1'b0;
   localparam r_state_t R_DATA = 1'b1;

   // Replace only the byte lanes whose strobe bit is set.
   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) begin
            res[8*i +: 8] = new_val[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_val[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/led_blink_gen.sv
// ----------------------------------------------------------------------------
// led_blink_gen
// Blink generator: a 32-bit counter wraps at period-1 and toggles a phase
// bit on each wrap; LEDs are dark while phase=1, show pattern otherwise.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   period    : cycles per phase (0 stops blinking)
//   enable    : blink enable (CTRL bit)
//   clear     : one-cycle pulse restarting counter and phase
//   pattern   : LED pattern to show in the lit phase
//   led       : registered LED drive
// ----------------------------------------------------------------------------
module led_blink_gen #(
   parameter int LED_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          period,
   input  logic                 enable,
   input  logic                 clear,
   input  logic [LED_WIDTH-1:0] pattern,
   output logic [LED_WIDTH-1:0] led
);

   logic [31:0]          cnt_r;
   logic                 phase_r;
   logic [LED_WIDTH-1:0] led_r;

   // Counter and phase; held at zero whenever blinking is not active.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r   <= 32'd0;
         phase_r <= 1'b0;
      end else if (clear || !enable || (period == 32'd0)) begin
         cnt_r   <= 32'd0;
         phase_r <= 1'b0;
      end else if (cnt_r == (period - 32'd1)) begin
         cnt_r   <= 32'd0;
         phase_r <= ~phase_r;
      end else begin
         cnt_r   <= cnt_r + 32'd1;
      end
   end

   // Registered LED drive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_r <= {LED_WIDTH{1'b0}};
      end else if (phase_r) begin
         led_r <= {LED_WIDTH{1'b0}};
      end else begin
         led_r <= pattern;
      end
   end

   assign led = led_r;

endmodule

// File: rtl/led_control_axil_slave.sv
// ----------------------------------------------------------------------------
// led_control_axil_slave
// AXI4-Lite slave with four 32-bit registers (PATTERN 0x0, PERIOD 0x4,
// CTRL 0x8, SCRATCH 0xC) driving an LED bank.
// Ports: ACLK / ARESET (async, active high); AXI4-Lite AW, W, B, AR, R
// channels (S_AXI_*); led_o = LED drive (1 = lit).
// Optional feature: define LED_CONTROL_BLINK_EN to build the blink
// generator (CTRL[0] enables blinking at PERIOD cycles per phase).
// Without it, led_o simply follows PATTERN.
// ----------------------------------------------------------------------------
module led_control_axil_slave
   import led_control_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int LED_WIDTH          = 8
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [LED_WIDTH-1:0]            led_o
);

   w_state_t    w_state_r;
   logic        awready_r, wready_r, bvalid_r;
   logic        aw_done_r, w_done_r;
   logic [1:0]  aw_idx_r;
   logic [31:0] wdata_r;
   logic [3:0]  wstrb_r;

   r_state_t    r_state_r;
   logic        arready_r, rvalid_r;
   logic [31:0] rdata_r;

   logic [31:0] pattern_r, period_r, ctrl_r, scratch_r;

   logic        aw_hs_s, w_hs_s, aw_have_s, w_have_s, wr_fire_s;
   logic [1:0]  wr_idx_s;
   logic [31:0] wr_data_s;
   logic [3:0]  wr_strb_s;
   logic [31:0] rd_mux_s;
   logic        unused_bits_s;

   // PROT and the byte-offset address bits carry no meaning here.
   assign unused_bits_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

   // Write-path handshakes; a beat captured this edge or earlier counts as held.
   always_comb begin
      aw_hs_s   = S_AXI_AWVALID && awready_r;
      w_hs_s    = S_AXI_WVALID && wready_r;
      aw_have_s = aw_done_r || aw_hs_s;
      w_have_s  = w_done_r || w_hs_s;
      wr_fire_s = (w_state_r == W_IDLE) && aw_have_s && w_have_s;
      if (aw_hs_s) begin
         wr_idx_s = S_AXI_AWADDR[3:2];
      end else begin
         wr_idx_s = aw_idx_r;
      end
      if (w_hs_s) begin
         wr_data_s = S_AXI_WDATA;
         wr_strb_s = S_AXI_WSTRB;
      end else begin
         wr_data_s = wdata_r;
         wr_strb_s = wstrb_r;
      end
   end

   // Write FSM: collect AW and W in any order, then issue one response.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         w_state_r <= W_IDLE;
         awready_r <= 1'b0;
         wready_r  <= 1'b0;
         bvalid_r  <= 1'b0;
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
         aw_idx_r  <= 2'd0;
         wdata_r   <= 32'd0;
         wstrb_r   <= 4'd0;
      end else begin
         case (w_state_r)
            W_IDLE: begin
               if (wr_fire_s) begin
                  w_state_r <= W_RESP;
                  bvalid_r  <= 1'b1;
                  awready_r <= 1'b0;
                  wready_r  <= 1'b0;
                  aw_done_r <= 1'b0;
                  w_done_r  <= 1'b0;
               end else begin
                  aw_done_r <= aw_have_s;
                  w_done_r  <= w_have_s;
                  awready_r <= !aw_have_s;
                  wready_r  <= !w_have_s;
                  if (aw_hs_s) aw_idx_r <= S_AXI_AWADDR[3:2];
                  if (w_hs_s) begin
                     wdata_r <= S_AXI_WDATA;
                     wstrb_r <= S_AXI_WSTRB;
                  end
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  w_state_r <= W_IDLE;
                  bvalid_r  <= 1'b0;
                  awready_r <= 1'b1;
                  wready_r  <= 1'b1;
               end
            end
            default: begin
               w_state_r <= W_IDLE;
               bvalid_r  <= 1'b0;
               awready_r <= 1'b0;
               wready_r  <= 1'b0;
            end
         endcase
      end
   end

   // Register file, updated on the edge the second write beat arrives.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         pattern_r <= 32'd0;
         period_r  <= 32'd0;
         ctrl_r    <= 32'd0;
         scratch_r <= 32'd0;
      end else if (wr_fire_s) begin
         case ({wr_idx_s, 2'b00})
            REG_PATTERN_OFF: pattern_r <= apply_wstrb(pattern_r, wr_data_s, wr_strb_s);
            REG_PERIOD_OFF:  period_r  <= apply_wstrb(period_r,  wr_data_s, wr_strb_s);
            REG_CTRL_OFF:    ctrl_r    <= apply_wstrb(ctrl_r,    wr_data_s, wr_strb_s);
            REG_SCRATCH_OFF: scratch_r <= apply_wstrb(scratch_r, wr_data_s, wr_strb_s);
            default: ;
         endcase
      end
   end

   // Read data mux on the AR address.
   always_comb begin
      case ({S_AXI_ARADDR[3:2], 2'b00})
         REG_PATTERN_OFF: rd_mux_s = pattern_r;
         REG_PERIOD_OFF:  rd_mux_s = period_r;
         REG_CTRL_OFF:    rd_mux_s = ctrl_r;
         REG_SCRATCH_OFF: rd_mux_s = scratch_r;
         default:         rd_mux_s = 32'd0;
      endcase
   end

   // Read FSM; sampling the registers before this edge's write lands gives
   // a same-cycle read the old value.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_state_r <= R_IDLE;
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
         rdata_r   <= 32'd0;
      end else begin
         case (r_state_r)
            R_IDLE: begin
               if (S_AXI_ARVALID && arready_r) begin
                  r_state_r <= R_DATA;
                  rdata_r   <= rd_mux_s;
                  rvalid_r  <= 1'b1;
                  arready_r <= 1'b0;
               end else begin
                  arready_r <= 1'b1;
               end
            end
            R_DATA: begin
               if (S_AXI_RREADY) begin
                  r_state_r <= R_IDLE;
                  rvalid_r  <= 1'b0;
                  arready_r <= 1'b1;
               end
            end
            default: begin
               r_state_r <= R_IDLE;
               rvalid_r  <= 1'b0;
               arready_r <= 1'b0;
            end
         endcase
      end
   end

   assign S_AXI_AWREADY = awready_r;
   assign S_AXI_WREADY  = wready_r;
   assign S_AXI_BVALID  = bvalid_r;
   assign S_AXI_BRESP   = RESP_OKAY;
   assign S_AXI_ARREADY = arready_r;
   assign S_AXI_RVALID  = rvalid_r;
   assign S_AXI_RDATA   = rdata_r;
   assign S_AXI_RRESP   = RESP_OKAY;

`ifdef LED_CONTROL_BLINK_EN
   logic blink_clear_s;

   // Any write to PERIOD or CTRL restarts the blink sequence.
   always_comb begin
      blink_clear_s = wr_fire_s && (({wr_idx_s, 2'b00} == REG_PERIOD_OFF) ||
                                    ({wr_idx_s, 2'b00} == REG_CTRL_OFF));
   end

   led_blink_gen #(
      .LED_WIDTH (LED_WIDTH)
   ) u_blink (
      .clk     (ACLK),
      .rst     (ARESET),
      .period  (period_r),
      .enable  (ctrl_r[CTRL_BLINK_EN_BIT]),
      .clear   (blink_clear_s),
      .pattern (pattern_r[LED_WIDTH-1:0]),
      .led     (led_o)
   );
`else
   logic [LED_WIDTH-1:0] led_r;

   // LEDs follow PATTERN one cycle after it is written.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         led_r <= {LED_WIDTH{1'b0}};
      end else begin
         led_r <= pattern_r[LED_WIDTH-1:0];
      end
   end

   assign led_o = led_r;
`endif

endmodule

// File: tb/tb_led_control_axil_slave.sv
// ----------------------------------------------------------------------------
// tb_led_control_axil_slave
// Self-checking bench for led_control_axil_slave: directed scenarios plus
// randomized register traffic compared against an array-based register model.
// Blink expectations depend on LED_CONTROL_BLINK_EN.
// ----------------------------------------------------------------------------
module tb_led_control_axil_slave;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [3:0]  S_AXI_AWADDR;
   logic [2:0]  S_AXI_AWPROT;
   logic        S_AXI_AWVALID;
   logic        S_AXI_AWREADY;
   logic [31:0] S_AXI_WDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_WVALID;
   logic        S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP;
   logic        S_AXI_BVALID;
   logic        S_AXI_BREADY;
   logic [3:0]  S_AXI_ARADDR;
   logic [2:0]  S_AXI_ARPROT;
   logic        S_AXI_ARVALID;
   logic        S_AXI_ARREADY;
   logic [31:0] S_AXI_RDATA;
   logic [1:0]  S_AXI_RRESP;
   logic        S_AXI_RVALID;
   logic        S_AXI_RREADY;
   logic [7:0]  led_o;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model [4];

   led_control_axil_slave #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (4),
      .LED_WIDTH          (8)
   ) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARPROT  (S_AXI_ARPROT),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .led_o         (led_o)
   );

   always #5 ACLK = ~ACLK;

   // Register model merge: strobe bits select whole bytes of new data.
   function automatic logic [31:0] model_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0] strb);
      logic [31:0] mask;
      mask = 32'h0;
      for (int i = 0; i < 4; i++) if (strb[i]) mask = mask | (32'hFF << (8 * i));
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Bus write; ok=1 only if both beats were taken and a response came back.
   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic ok, output logic [1:0] resp);
      logic aw_hs, w_hs;
      ok = 1'b0;
      resp = 2'b11;
      S_AXI_AWADDR = addr; S_AXI_AWPROT = 3'($urandom_range(0, 7));
      S_AXI_WDATA = data; S_AXI_WSTRB = strb;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
      for (int c = 0; c < 20 && (S_AXI_AWVALID || S_AXI_WVALID); c++) begin
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID && S_AXI_WREADY;
         tick();
         if (aw_hs) S_AXI_AWVALID = 1'b0;
         if (w_hs) S_AXI_WVALID = 1'b0;
      end
      if (!S_AXI_AWVALID && !S_AXI_WVALID) begin
         S_AXI_BREADY = 1'b1;
         for (int c = 0; c < 20; c++) begin
            if (S_AXI_BVALID) begin
               ok = 1'b1;
               resp = S_AXI_BRESP;
               tick();
               break;
            end
            tick();
         end
      end
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic ok,
                           output logic [31:0] data, output logic [1:0] resp);
      logic ar_hs;
      ok = 1'b0;
      data = 32'hDEADBEEF;
      resp = 2'b11;
      S_AXI_ARADDR = addr; S_AXI_ARPROT = 3'($urandom_range(0, 7));
      S_AXI_ARVALID = 1'b1;
      for (int c = 0; c < 20 && S_AXI_ARVALID; c++) begin
         ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
         tick();
         if (ar_hs) S_AXI_ARVALID = 1'b0;
      end
      if (!S_AXI_ARVALID) begin
         S_AXI_RREADY = 1'b1;
         for (int c = 0; c < 20; c++) begin
            if (S_AXI_RVALID) begin
               ok = 1'b1;
               data = S_AXI_RDATA;
               resp = S_AXI_RRESP;
               tick();
               break;
            end
            tick();
         end
      end
      S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      for (int i = 0; i < 4; i++) model[i] = 32'h0;
      repeat (3) tick();
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
      end
      checks++;
      if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, led_o} !== 46'h0) begin
         errors++;
         $display("FAIL reset_outputs: bvalid=%b rvalid=%b rdata=%h led=%h expected all zero",
                  S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA, led_o);
      end
      ARESET = 1'b0;
      tick();
      checks++;
      if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
         errors++;
         $display("FAIL release_ready: got %b expected 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
      end
   endtask

   task automatic test_basic_rw();
      logic ok; logic [1:0] resp; logic [31:0] rd;
      for (int i = 0; i < 4; i++) begin
         axi_write(4'(4 * i), 32'(i + 1), 4'hF, ok, resp);
         model[i] = 32'(i + 1);
         checks++;
         if ({ok, resp} !== 3'b100) begin
            errors++;
            $display("FAIL basic_write[%0d]: ok=%b bresp=%b expected ok=1 bresp=00", i, ok, resp);
         end
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(4 * i), ok, rd, resp);
         checks++;
         if ({ok, resp, rd} !== {1'b1, 2'b00, 32'(i + 1)}) begin
            errors++;
            $display("FAIL basic_read[%0d]: ok=%b rresp=%b rdata=%h expected %h", i, ok, resp, rd, 32'(i + 1));
         end
      end
   endtask

   task automatic test_wstrb();
      logic ok; logic [1:0] resp; logic [31:0] rd;
      axi_write(4'hC, 32'hFFFFFFFF, 4'hF, ok, resp);
      axi_write(4'hC, 32'h00000000, 4'b0101, ok, resp);
      model[3] = 32'hFF00FF00;
      axi_read(4'hC, ok, rd, resp);
      checks++;
      if (rd !== 32'hFF00FF00) begin
         errors++;
         $display("FAIL wstrb_merge: got %h expected ff00ff00", rd);
      end
   endtask

   task automatic test_w_before_aw();
      logic [31:0] d;
      int bad;
      d = $urandom;
      S_AXI_WDATA = d; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
      S_AXI_AWVALID = 1'b0; S_AXI_BREADY = 1'b0;
      tick();
      S_AXI_WVALID = 1'b0;
      checks++;
      if ({S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID} !== 3'b010) begin
         errors++;
         $display("FAIL w_first_capture: wready/awready/bvalid=%b expected 010",
                  {S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID});
      end
      repeat (2) tick();
      S_AXI_AWADDR = 4'hC; S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      model[3] = d;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY} !== 5'b10000) bad++;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL bvalid_hold: %0d bad cycles, expected 0", bad);
      end
      S_AXI_BREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0;
      checks++;
      if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b011) begin
         errors++;
         $display("FAIL bresp_done: bvalid/awready/wready=%b expected 011",
                  {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
      end
   endtask

   task automatic test_concurrent();
      logic ok; logic [1:0] resp; logic [31:0] rd;
      axi_write(4'h0, 32'h11, 4'hF, ok, resp);
      model[0] = 32'h11;
      S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h5A; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 4'h0;
      S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      checks++;
      if ({S_AXI_RVALID, S_AXI_BVALID, S_AXI_RDATA} !== {2'b11, 32'h11}) begin
         errors++;
         $display("FAIL same_cycle_rw: rvalid=%b bvalid=%b rdata=%h expected 1 1 00000011",
                  S_AXI_RVALID, S_AXI_BVALID, S_AXI_RDATA);
      end
      S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
      tick();
      S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
      model[0] = 32'h5A;
      axi_read(4'h0, ok, rd, resp);
      checks++;
      if (rd !== 32'h5A) begin
         errors++;
         $display("FAIL after_same_cycle: got %h expected 0000005a", rd);
      end
   endtask

   task automatic test_led();
      logic ok; logic [1:0] resp;
      logic [7:0] vals [48];
      int bad, last, ntr, badgap;
      axi_write(4'h0, 32'hA5, 4'hF, ok, resp); model[0] = 32'hA5;
      axi_write(4'h4, 32'd4, 4'hF, ok, resp);  model[1] = 32'd4;
      axi_write(4'h8, 32'd1, 4'hF, ok, resp);  model[2] = 32'd1;
      for (int c = 0; c < 48; c++) begin
         vals[c] = led_o;
         tick();
      end
`ifdef LED_CONTROL_BLINK_EN
      bad = 0; ntr = 0; badgap = 0; last = -1;
      for (int c = 0; c < 48; c++) begin
         if (vals[c] !== 8'hA5 && vals[c] !== 8'h00) bad++;
         if (c > 0 && vals[c] !== vals[c-1]) begin
            if (last >= 0 && (c - last) != 4) badgap++;
            last = c;
            ntr++;
         end
      end
      checks++;
      if (bad !== 0 || badgap !== 0 || ntr < 10) begin
         errors++;
         $display("FAIL led_blink: bad_values=%0d bad_gaps=%0d toggles=%0d expected 0 0 >=10", bad, badgap, ntr);
      end
`else
      bad = 0;
      for (int c = 0; c < 48; c++) if (vals[c] !== 8'hA5) bad++;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL led_steady: %0d cycles not a5, expected 0", bad);
      end
`endif
      axi_write(4'h8, 32'd0, 4'hF, ok, resp); model[2] = 32'd0;
      repeat (2) tick();
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         if (led_o !== model[0][7:0]) bad++;
         tick();
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL led_pattern: %0d cycles differ from %h, expected 0", bad, model[0][7:0]);
      end
   endtask

   task automatic test_random();
      logic ok; logic [1:0] resp; logic [31:0] rd, d;
      logic [3:0] strb;
      int idx, bad;
      bad = 0;
      for (int n = 0; n < 40; n++) begin
         idx = $urandom_range(0, 3);
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom; strb = 4'($urandom_range(0, 15));
            axi_write({2'(idx), 2'($urandom_range(0, 3))}, d, strb, ok, resp);
            model[idx] = model_merge(model[idx], d, strb);
            if ({ok, resp} !== 3'b100) bad++;
         end else begin
            axi_read({2'(idx), 2'($urandom_range(0, 3))}, ok, rd, resp);
            checks++;
            if ({ok, resp, rd} !== {3'b100, model[idx]}) begin
               errors++;
               $display("FAIL random_read[%0d]: ok=%b rresp=%b got %h expected %h", idx, ok, resp, rd, model[idx]);
            end
         end
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL random_write_resp: %0d bad responses, expected 0", bad);
      end
   endtask

   task automatic test_reset_mid();
      logic ok; logic [1:0] resp; logic [31:0] rd;
      int bad;
      for (int i = 0; i < 4; i++) axi_write(4'(4 * i), $urandom | 32'h1, 4'hF, ok, resp);
      S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b0;
      tick();
      S_AXI_AWVALID = 1'b0;
      checks++;
      if (S_AXI_AWREADY !== 1'b0) begin
         errors++;
         $display("FAIL aw_accepted: awready=%b expected 0", S_AXI_AWREADY);
      end
      ARESET = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) model[i] = 32'h0;
      checks++;
      if ({led_o, S_AXI_BVALID} !== 9'h0) begin
         errors++;
         $display("FAIL mid_reset_async: led=%h bvalid=%b expected 00 0", led_o, S_AXI_BVALID);
      end
      repeat (2) tick();
      ARESET = 1'b0;
      S_AXI_WDATA = 32'hFFFFFFFF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b0;
      bad = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (!S_AXI_WREADY) S_AXI_WVALID = 1'b0;
         if (S_AXI_BVALID !== 1'b0) bad++;
      end
      S_AXI_WVALID = 1'b0;
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL no_resp_after_reset: bvalid high %0d cycles, expected 0", bad);
      end
      for (int i = 0; i < 4; i++) begin
         axi_read(4'(4 * i), ok, rd, resp);
         checks++;
         if ({ok, rd} !== {1'b1, model[i]}) begin
            errors++;
            $display("FAIL reset_regs[%0d]: ok=%b got %h expected %h", i, ok, rd, model[i]);
         end
      end
      checks++;
      if (led_o !== 8'h00) begin
         errors++;
         $display("FAIL reset_led: got %h expected 00", led_o);
      end
   endtask

   initial begin
      ARESET = 1'b1;
      S_AXI_AWADDR = 4'h0; S_AXI_AWPROT = 3'b000; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b0;
      S_AXI_ARADDR = 4'h0; S_AXI_ARPROT = 3'b000; S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY = 1'b0;
      #1;
      test_reset();
      test_basic_rw();
      test_wstrb();
      test_w_before_aw();
      test_concurrent();
      test_led();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
